// File: rtl/cnt60_second.sv
// Seconds stage of the digital clock: 1 Hz prescaler, BCD 00-59 counter with minute carry,
// and a synchronised, debounced key that steps the seconds while in setting mode.
module cnt60_second #(
   parameter int unsigned TICK_DIV        = 100_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       CLR_n,
   input  logic       isSetting,
   input  logic       second_setting,
   output logic [3:0] sec_one,
   output logic [3:0] sec_ten,
   output logic       bit6,
   output logic       tick
);

   localparam int unsigned PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [PW-1:0]  presc_q, presc_d;
   logic [3:0]     one_q, one_d, ten_q, ten_d;
   logic           tick_q, tick_d, bit6_q, bit6_d;
   logic           sync1_q, sync1_d, sync2_q, sync2_d;
   logic           deb_q, deb_d, deb_dly_q, deb_dly_d;
   logic [DCW-1:0] deb_cnt_q, deb_cnt_d;

   logic           press;
   logic           at_59;
   logic [3:0]     adv_one, adv_ten;

   // Key path: any cycle where s2 matches the accepted level restarts the stability count.
   always_comb begin
      sync1_d   = second_setting;
      sync2_d   = sync1_q;
      deb_dly_d = deb_q;
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (deb_cnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DCW'(1);
         end
      end
   end

   assign press = deb_q & ~deb_dly_q;
   assign at_59 = (ten_q == 4'd5) && (one_q == 4'd9);

   always_comb begin
      adv_one = one_q + 4'd1;
      adv_ten = ten_q;
      if (one_q == 4'd9) begin
         adv_one = '0;
         adv_ten = (ten_q == 4'd5) ? 4'd0 : ten_q + 4'd1;
      end
   end

   // Setting mode holds the prescaler and suppresses tick/bit6, so a set-mode wrap never carries.
   always_comb begin
      presc_d = presc_q + PW'(1);
      one_d   = one_q;
      ten_d   = ten_q;
      tick_d  = 1'b0;
      bit6_d  = 1'b0;
      if (isSetting) begin
         presc_d = '0;
         if (press) begin
            one_d = adv_one;
            ten_d = adv_ten;
         end
      end else if (presc_q == PW'(TICK_DIV - 1)) begin
         presc_d = '0;
         tick_d  = 1'b1;
         bit6_d  = at_59;
         one_d   = adv_one;
         ten_d   = adv_ten;
      end
   end

   always_ff @(posedge clk) begin
      if (CLR_n) begin
         presc_q   <= '0;
         one_q     <= '0;
         ten_q     <= '0;
         tick_q    <= 1'b0;
         bit6_q    <= 1'b0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 1'b0;
         deb_dly_q <= 1'b0;
         deb_cnt_q <= '0;
      end else begin
         presc_q   <= presc_d;
         one_q     <= one_d;
         ten_q     <= ten_d;
         tick_q    <= tick_d;
         bit6_q    <= bit6_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   assign sec_one = one_q;
   assign sec_ten = ten_q;
   assign tick    = tick_q;
   assign bit6    = bit6_q;

endmodule

// File: tb/tb_cnt60_second.sv
// Scoreboard bench for cnt60_second: stimulus queues hand-computed expectations tagged with the
// cycle they apply to; a negedge monitor pops and compares them.
module tb_cnt60_second;

   logic       clk = 1'b0;
   logic       CLR_n = 1'b1;
   logic       isSetting = 1'b0;
   logic       second_setting = 1'b0;
   logic [3:0] sec_one, sec_ten;
   logic       bit6, tick;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic [3:0] one;
      logic [3:0] ten;
      logic       tk;
      logic       b6;
      string      nm;
   } exp_t;

   exp_t sb[$];

   cnt60_second #(
      .TICK_DIV        (4),
      .DEBOUNCE_CYCLES (3)
   ) dut (
      .clk            (clk),
      .CLR_n          (CLR_n),
      .isSetting      (isSetting),
      .second_setting (second_setting),
      .sec_one        (sec_one),
      .sec_ten        (sec_ten),
      .bit6           (bit6),
      .tick           (tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected state after the edge that lies d edges from now (d=0: the edge just taken).
   task automatic exp(input int d, input int one, input int ten, input bit tk, input bit b6,
                      input string nm);
      exp_t e;
      e.cyc = cyc + d;
      e.one = 4'(one);
      e.ten = 4'(ten);
      e.tk  = tk;
      e.b6  = b6;
      e.nm  = nm;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      checks++;
      if (sec_one > 4'd9 || sec_ten > 4'd5) begin
         errors++;
         $display("FAIL bcd_range cyc=%0d got ten=%0d one=%0d expected ten<=5 one<=9",
                  cyc, sec_ten, sec_one);
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s missed: expected at cyc=%0d, now cyc=%0d", sb[i].nm, sb[i].cyc, cyc);
            sb.delete(i);
         end else if (sb[i].cyc == cyc) begin
            checks++;
            if (sec_one !== sb[i].one || sec_ten !== sb[i].ten ||
                tick !== sb[i].tk || bit6 !== sb[i].b6) begin
               errors++;
               $display("FAIL %s cyc=%0d got ten=%0d one=%0d tick=%0b bit6=%0b expected ten=%0d one=%0d tick=%0b bit6=%0b",
                        sb[i].nm, cyc, sec_ten, sec_one, tick, bit6,
                        sb[i].ten, sb[i].one, sb[i].tk, sb[i].b6);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      // Reset then run
      step(2);
      exp(0, 0, 0, 0, 0, "reset");
      CLR_n = 1'b0;
      exp(3, 0, 0, 0, 0, "pre_tick1");
      exp(4, 1, 0, 1, 0, "tick1");
      exp(5, 1, 0, 0, 0, "tick1_fall");
      exp(7, 1, 0, 0, 0, "between_ticks");
      exp(8, 2, 0, 1, 0, "tick2");
      step(8);

      // Full-minute wrap: now at 02 with prescaler 0
      exp(32, 0, 1, 1, 0, "sec10");
      exp(231, 9, 5, 0, 0, "sec59");
      exp(232, 0, 0, 1, 1, "wrap1");
      exp(233, 0, 0, 0, 0, "wrap1_fall");
      exp(236, 1, 0, 1, 0, "post_wrap1");
      exp(471, 9, 5, 0, 0, "sec59_b");
      exp(472, 0, 0, 1, 1, "wrap2");
      step(472);

      // Reset on a bit6-high cycle
      CLR_n = 1'b1;
      exp(1, 0, 0, 0, 0, "rst_on_bit6");
      step(1);
      CLR_n = 1'b0;
      exp(3, 0, 0, 0, 0, "post_rst_pre");
      exp(4, 1, 0, 1, 0, "post_rst_tick");
      step(4);

      // Reset at 37
      step(144);
      exp(0, 7, 3, 1, 0, "at37");
      CLR_n = 1'b1;
      exp(1, 0, 0, 0, 0, "rst37");
      step(1);
      CLR_n = 1'b0;
      exp(3, 0, 0, 0, 0, "post_rst37_pre");
      exp(4, 1, 0, 1, 0, "post_rst37_tick");
      step(4);

      // Setting increments from 58
      step(228);
      exp(0, 8, 5, 1, 0, "at58");
      isSetting      = 1'b1;
      second_setting = 1'b1;
      exp(1, 8, 5, 0, 0, "set_enter");
      exp(5, 8, 5, 0, 0, "set_pre_press");
      exp(6, 9, 5, 0, 0, "set_59");
      exp(10, 9, 5, 0, 0, "set_held_once");
      step(10);
      second_setting = 1'b0;
      step(8);
      second_setting = 1'b1;
      exp(5, 9, 5, 0, 0, "set_pre_wrap");
      exp(6, 0, 0, 0, 0, "set_wrap_no_bit6");
      exp(7, 0, 0, 0, 0, "set_wrap_after");
      step(10);
      second_setting = 1'b0;
      step(8);

      // Bounce rejection in setting mode
      for (int i = 0; i < 12; i++) begin
         second_setting = ~second_setting;
         step(1);
      end
      second_setting = 1'b0;
      exp(8, 0, 0, 0, 0, "bounce_rejected");
      step(8);

      // Press in run mode is discarded, not queued
      isSetting      = 1'b0;
      second_setting = 1'b1;
      exp(3, 0, 0, 0, 0, "leave_pre_tick");
      exp(4, 1, 0, 1, 0, "leave_tick");
      exp(8, 2, 0, 1, 0, "run_tick2");
      exp(9, 2, 0, 0, 0, "run_press_ignored");
      exp(12, 2, 0, 0, 0, "ign_enter_set");
      exp(20, 2, 0, 0, 0, "ign_no_queue");
      exp(23, 2, 0, 0, 0, "resume_pre");
      exp(24, 3, 0, 1, 0, "resume_tick");
      step(10);
      second_setting = 1'b0;
      isSetting      = 1'b1;
      step(10);
      isSetting = 1'b0;
      step(4);

      for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cnt60_second.md
# cnt60_second

Seconds stage of the digital clock: divides the system clock to a 1 Hz tick, counts seconds 00–59 in two BCD digits, and emits the `bit6` carry that drives the minute-units counter directly downstream. It also owns the seconds-setting path: a synchronised, debounced `second_setting` key advances seconds by one per press while `isSetting` is high, with counting frozen and no carry generated.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per second; the prescaler counts 0..TICK_DIV-1.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required before a key level is accepted. Must be ≥1.
- `clk` input 1: system clock; all state changes on its rising edge.
- `CLR_n` input 1: synchronous, active-high reset, despite the suffix. It has priority over every other input.
- `isSetting` input 1: high selects setting mode.
- `second_setting` input 1: raw, asynchronous, bouncing key level; high means pressed.
- `sec_one` output 4: seconds units in BCD, range 0–9.
- `sec_ten` output 4: seconds tens in BCD, range 0–5.
- `bit6` output 1: minute carry. Registered, high for exactly one clk cycle when 59 wraps to 00 in run mode.
- `tick` output 1: registered 1 Hz strobe, high for one clk cycle on every run-mode second advance.

## Operation
- Reset (`CLR_n`=1 at an edge) sets these to zero: `sec_one`, `sec_ten`, `bit6`, `tick`, the prescaler, both synchroniser flops, the debounced level, its delayed copy, and the debounce counter.
- **Run mode** (`isSetting`=0):
  - The prescaler increments every cycle.
  - On the edge where prescaler == TICK_DIV-1:
    - the prescaler goes to 0;
    - `tick`<=1;
    - the seconds advance;
    - `bit6`<=1 only if seconds were 59.
  - On every other edge, `tick`<=0 and `bit6`<=0.
- **Seconds advance:**
  - `sec_one`<9: `sec_one`+1.
  - Otherwise `sec_one`<=0, and `sec_ten` becomes `sec_ten`+1, or 0 if it was 5.
  - The BCD invariant holds at all times.
- **Setting mode** (`isSetting`=1):
  - The prescaler is held at 0.
  - `tick`<=0 and `bit6`<=0 every cycle, so the downstream minute stage never sees a carry edge while setting.
  - On a rising edge of the debounced key, the seconds advance once with the same wrap rule. The 59→00 wrap asserts neither `bit6` nor `tick`.
- **Key path** (runs in both modes):
  - A 2-flop synchroniser produces s2.
  - When s2 ≠ debounced level, the counter increments. When it reaches DEBOUNCE_CYCLES-1 with s2 still different, the debounced level <= s2 and the counter <= 0.
  - When s2 == debounced level, the counter <= 0, so any bounce restarts the count.
  - A press is the debounced level rising versus its delayed copy. Presses seen while `isSetting`=0 are discarded; they are not queued.
- **Mode change:**
  - Entering setting on the same edge where the prescaler == TICK_DIV-1 means setting wins: no advance, no `tick`.
  - On leaving setting, the prescaler restarts from 0.

## Timing
- After `CLR_n` deasserts, the first run-mode advance and `tick` occur on the TICK_DIV-th rising edge. After that they repeat every TICK_DIV cycles.
- `sec_one`, `sec_ten`, `tick` and `bit6` all update on the same edge. `bit6` and `tick` fall on the next edge.
- Key latency: if raw `second_setting` rises before edge 1 and stays stable, the debounced level rises at edge DEBOUNCE_CYCLES+2. The seconds change at edge DEBOUNCE_CYCLES+3.
- Release is debounced with the same latency. Exactly one increment occurs per accepted press, however long the key is held.
- The first run-mode advance after `isSetting` falls occurs TICK_DIV edges later.
- `CLR_n` asserted during a `bit6`/`tick`-high cycle forces both low on that edge.

## Test plan
All scenarios use TICK_DIV=4 and DEBOUNCE_CYCLES=3.
- **Reset then run:** reset for 2 cycles, then release → `sec_one`=1 and `tick`=1 at the 4th edge. `tick` is then high one cycle in every 4, and `bit6` stays 0.
- **Full-minute wrap:** run 240 cycles from 00 → 59→00 at the 60th tick, with `bit6`=1 and `tick`=1 for exactly that one cycle. Continue to 120 ticks → a second `bit6` pulse, and `sec_ten` never exceeds 5.
- **Setting increments:**
  - From 58 with `isSetting`=1, hold the key high for 10 cycles → 59 at edge 6 after the rise, with the prescaler frozen and `tick`=0.
  - Release, then press again → 00 with `bit6` still 0.
- **Bounce rejection:** in setting mode, toggle `second_setting` every cycle for 12 cycles, then hold low → seconds unchanged.
- **Ignored press in run mode:** with `isSetting`=0, press for 10 cycles, then raise `isSetting` → no extra increment in either mode.
- **Reset mid-operation:** assert `CLR_n` for one cycle at 37, and again on a `bit6`-high cycle → the next edge shows all outputs 0, and the next `tick` comes 4 edges after release.
